// File: rtl/io_bus_sequencer_if.sv
// Bus bundle between the CPU I/O strobes and the peripheral req/ack handshake.
// master = sequencer view, slave = CPU/peripheral side.
interface io_bus_sequencer_if #(
   parameter int NUM_DEV = 4,
   parameter int DW      = 32
);
   logic                  io_read;
   logic                  io_write;
   logic [9:0]            io_addr;
   logic [DW-1:0]         io_wdata;
   logic [DW-1:0]         io_rdata;
   logic                  io_stall;
   logic                  io_err;
   logic [NUM_DEV-1:0]    dev_sel;
   logic                  dev_we;
   logic [3:0]            dev_addr;
   logic [DW-1:0]         dev_wdata;
   logic [NUM_DEV*DW-1:0] dev_rdata;
   logic [NUM_DEV-1:0]    dev_ack;

   modport master (
      input  io_read, io_write, io_addr, io_wdata, dev_rdata, dev_ack,
      output io_rdata, io_stall, io_err, dev_sel, dev_we, dev_addr, dev_wdata
   );

   modport slave (
      output io_read, io_write, io_addr, io_wdata, dev_rdata, dev_ack,
      input  io_rdata, io_stall, io_err, dev_sel, dev_we, dev_addr, dev_wdata
   );
endinterface

// File: rtl/io_bus_sequencer.sv
// Multi-cycle I/O sequencer: decodes CPU I/O strobes, runs a req/ack handshake
// with the addressed peripheral and stalls the CPU. IO_BUS_SEQUENCER_STAT_EN adds io_count.
//
// state   | meaning
// IDLE    | waiting for a strobe; stall follows the strobe combinationally
// REQ     | dev_sel asserted, waiting for ack or timeout
// DONE    | one-cycle commit slot; io_rdata/io_err valid, stall low
module io_bus_sequencer #(
   parameter int NUM_DEV = 4,
   parameter int TIMEOUT = 15,
   parameter int DW      = 32
) (
   input  logic clock,
   input  logic reset,
   io_bus_sequencer_if.master bus
`ifdef IO_BUS_SEQUENCER_STAT_EN
   ,
   output logic [15:0] io_count
`endif
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state;
   logic [7:0]    tmo_cnt;
   logic [7:0]    tmo_nxt;
   logic          strobe;
   logic          illegal;
   logic [3:0]    dev_idx;
   logic          ack_hit;
   logic [DW-1:0] rdata_mux;
   logic          unused_addr;

   assign strobe      = bus.io_read | bus.io_write;
   assign dev_idx     = bus.io_addr[7:4];
   assign illegal     = (bus.io_read & bus.io_write) | (int'(dev_idx) >= NUM_DEV);
   assign ack_hit     = |(bus.dev_ack & bus.dev_sel);
   assign tmo_nxt     = tmo_cnt + 8'd1;
   assign unused_addr = ^bus.io_addr[9:8];

   // dev_sel is one-hot, so OR-ing the masked slices selects the active device
   always_comb begin
      rdata_mux = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (bus.dev_sel[i]) rdata_mux = rdata_mux | bus.dev_rdata[i*DW +: DW];
      end
   end

   assign bus.io_stall = !reset && ((state == ST_IDLE && strobe) || state == ST_REQ);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         tmo_cnt       <= '0;
         bus.dev_sel   <= '0;
         bus.dev_we    <= 1'b0;
         bus.dev_addr  <= '0;
         bus.dev_wdata <= '0;
         bus.io_rdata  <= '0;
         bus.io_err    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.io_err <= 1'b0;
               if (strobe) begin
                  if (illegal) begin
                     bus.io_err   <= 1'b1;
                     bus.io_rdata <= '0;
                     state        <= ST_DONE;
                  end else begin
                     bus.dev_sel   <= NUM_DEV'(1) << dev_idx;
                     bus.dev_we    <= bus.io_write;
                     bus.dev_addr  <= bus.io_addr[3:0];
                     bus.dev_wdata <= bus.io_wdata;
                     tmo_cnt       <= '0;
                     state         <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               // an ack on the terminal cycle still completes successfully
               if (ack_hit) begin
                  if (!bus.dev_we) bus.io_rdata <= rdata_mux;
                  bus.dev_sel <= '0;
                  state       <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_nxt;
                  if (tmo_nxt == 8'(TIMEOUT)) begin
                     bus.dev_sel  <= '0;
                     bus.io_err   <= 1'b1;
                     bus.io_rdata <= '0;
                     state        <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               bus.io_err <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               bus.io_err <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef IO_BUS_SEQUENCER_STAT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_count <= '0;
      end else if (state == ST_DONE && !bus.io_err && io_count != 16'hFFFF) begin
         io_count <= io_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Directed bench for io_bus_sequencer with a scoreboard of expected completions.
module tb_io_bus_sequencer;
   localparam int NUM_DEV = 4;
   localparam int TIMEOUT = 15;
   localparam int DW      = 32;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          stall;
   } exp_t;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_err;
   logic [31:0] model_rdata;
   int   exp_count;
   exp_t sb[$];

   io_bus_sequencer_if #(.NUM_DEV(NUM_DEV), .DW(DW)) bus ();

`ifdef IO_BUS_SEQUENCER_STAT_EN
   logic [15:0] io_count;
   io_bus_sequencer #(.NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT), .DW(DW)) dut (
      .clock(clock), .reset(reset), .bus(bus), .io_count(io_count));
`else
   io_bus_sequencer #(.NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT), .DW(DW)) dut (
      .clock(clock), .reset(reset), .bus(bus));
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_count();
`ifdef IO_BUS_SEQUENCER_STAT_EN
      check("io_count", 32'(io_count), 32'(exp_count));
`endif
   endtask

   // Entered and left just after a negedge while the DUT is in IDLE.
   task automatic access(input logic rd, input logic wr, input logic [9:0] addr,
                         input logic [31:0] wdata, input int ack_at,
                         input logic [31:0] ack_data, input int noise_dev);
      exp_t e;
      exp_t got;
      int   cyc;
      int   di;
      bit   early;
      logic [3:0] exp_sel;
      di    = int'(addr[7:4]);
      early = (rd && wr) || di >= NUM_DEV;
      e.err   = early || ack_at == 0 || ack_at > TIMEOUT;
      e.stall = early ? 1 : (e.err ? 1 + TIMEOUT : 1 + ack_at);
      e.rdata = e.err ? 32'h0 : (rd ? ack_data : model_rdata);
      model_rdata = e.rdata;
      if (!e.err) exp_count++;
      sb.push_back(e);
      exp_sel = early ? 4'b0000 : (4'b0001 << di);

      bus.io_read  = rd;
      bus.io_write = wr;
      bus.io_addr  = addr;
      bus.io_wdata = wdata;
      cyc = 0;
      #1;
      while (bus.io_stall && cyc < 40) begin
         cyc++;
         bus.dev_ack = '0;
         if (cyc >= 2) begin
            check("dev_sel", 32'(bus.dev_sel), 32'(exp_sel));
            check("dev_we", 32'(bus.dev_we), 32'(wr));
            check("dev_addr", 32'(bus.dev_addr), 32'(addr[3:0]));
            check("dev_wdata", bus.dev_wdata, wdata);
            if (noise_dev >= 0) begin
               bus.dev_ack[noise_dev] = 1'b1;
               bus.dev_rdata[noise_dev*DW +: DW] = 32'hDEAD_0000 | 32'(cyc);
            end
            if (!early && ack_at == cyc - 1) begin
               bus.dev_ack[di] = 1'b1;
               bus.dev_rdata[di*DW +: DW] = ack_data;
            end
         end
         @(negedge clock);
         #1;
      end
      bus.dev_ack = '0;
      got = sb.pop_front();
      check("stall_cycles", 32'(cyc), 32'(got.stall));
      check("done_err", 32'(bus.io_err), 32'(got.err));
      check("done_rdata", bus.io_rdata, got.rdata);
      check("done_sel", 32'(bus.dev_sel), 32'h0);
      @(negedge clock);
      bus.io_read  = 1'b0;
      bus.io_write = 1'b0;
      #1;
      check("idle_sel", 32'(bus.dev_sel), 32'h0);
      check("idle_err", 32'(bus.io_err), 32'h0);
      check("idle_stall", 32'(bus.io_stall), 32'h0);
      check_count();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_rdata = '0;
      exp_count = 0;
      reset = 1'b1;
      bus.io_read   = 1'b0;
      bus.io_write  = 1'b0;
      bus.io_addr   = '0;
      bus.io_wdata  = '0;
      bus.dev_rdata = '0;
      bus.dev_ack   = '0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         #1;
         check("rst_stall", 32'(bus.io_stall), 32'h0);
         check("rst_sel", 32'(bus.dev_sel), 32'h0);
         check("rst_err", 32'(bus.io_err), 32'h0);
         check("rst_rdata", bus.io_rdata, 32'h0);
         check("rst_we_addr", {27'h0, bus.dev_we, bus.dev_addr}, 32'h0);
         check("rst_wdata", bus.dev_wdata, 32'h0);
         check_count();
         @(negedge clock);
      end

      access(1'b1, 1'b0, 10'h012, 32'h0, 1, 32'hA5A5_0001, -1);
      access(1'b0, 1'b1, 10'h030, 32'h55, 5, 32'h0, -1);
      access(1'b1, 1'b0, 10'h020, 32'h0, 0, 32'h0, 0);
      access(1'b1, 1'b0, 10'h004, 32'h0, 2, 32'h1234_5678, -1);
      access(1'b0, 1'b1, 10'h050, 32'h99, 0, 32'h0, -1);
      access(1'b1, 1'b0, 10'h01C, 32'h0, 3, 32'h0BAD_BEEF, -1);
      access(1'b1, 1'b1, 10'h010, 32'h77, 1, 32'h0, -1);
      access(1'b1, 1'b0, 10'h331, 32'h0, TIMEOUT, 32'hCAFE_F00D, -1);
      access(1'b0, 1'b1, 10'h02F, 32'hFFFF_0000, 1, 32'h0, 1);

      // reset in the 3rd REQ cycle of a read that never gets acked
      bus.io_read = 1'b1;
      bus.io_addr = 10'h010;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      #1;
      check("req3_sel", 32'(bus.dev_sel), 32'h2);
      check_count();
      reset = 1'b1;
      #1;
      check("arst_sel", 32'(bus.dev_sel), 32'h0);
      check("arst_stall", 32'(bus.io_stall), 32'h0);
      check("arst_err", 32'(bus.io_err), 32'h0);
      model_rdata = '0;
      exp_count = 0;
      @(negedge clock);
      bus.io_read = 1'b0;
      reset = 1'b0;
      #1;
      check("post_rst_rdata", bus.io_rdata, 32'h0);
      check("post_rst_err", 32'(bus.io_err), 32'h0);
      check_count();
      @(negedge clock);
      #1;
      check("post_rst_err2", 32'(bus.io_err), 32'h0);
      check("post_rst_sel", 32'(bus.dev_sel), 32'h0);
      @(negedge clock);

      access(1'b1, 1'b0, 10'h008, 32'h0, 1, 32'h0000_1357, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/io_bus_sequencer.md
Name: io_bus_sequencer

Overview:
- Multi-cycle sequencer between the single-cycle CPU's I/O strobes and slow memory-mapped peripherals (switches, LEDs, seven-segment, UART).
- Takes IORead/IOWrite from the control unit for the 0xFFFFFC00–0xFFFFFFFF window and decodes the target device.
- Runs a req/ack handshake with that device and stalls the CPU until the device acknowledges or the access times out.

Parameters:
- NUM_DEV, 4, number of peripheral slots (1..16).
- TIMEOUT, 15, REQ cycles without ack before abort (1..255).
- DW, 32, data width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- io_read  in  1  CPU I/O read strobe (lw to I/O window).
- io_write  in  1  CPU I/O write strobe (sw to I/O window).
- io_addr  in  10  ALU result [9:0]; [7:4] = device index, [3:0] = register offset, [9:8] ignored.
- io_wdata  in  DW  store data from the register file.
- io_rdata  out  DW  load data returned to the writeback mux.
- io_stall  out  1  holds PC and register-file write while high.
- io_err  out  1  one-cycle pulse on an errored access.
- dev_sel  out  NUM_DEV  one-hot device request.
- dev_we  out  1  1 = write, 0 = read.
- dev_addr  out  4  register offset.
- dev_wdata  out  DW  write data.
- dev_rdata  in  NUM_DEV*DW  packed read data; device i at [i*DW +: DW].
- dev_ack  in  NUM_DEV  per-device acknowledge.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - dev_sel = 0, dev_we = 0, dev_addr = 0, dev_wdata = 0, io_rdata = 0, io_err = 0, timeout counter = 0.
  - io_stall = 0 while reset is high.
  - Reset mid-transaction drops dev_sel immediately, with no completion and no error.
- IDLE:
  - io_stall = io_read | io_write, combinational in the same cycle.
  - On a strobe with device index < NUM_DEV:
    - Register dev_sel = onehot(index), dev_we = io_write, dev_addr = io_addr[3:0], dev_wdata = io_wdata.
    - Clear the counter and go to REQ.
  - Device index >= NUM_DEV: go to DONE with an error and io_rdata = 0; no dev_sel is issued.
  - io_read and io_write both high: illegal. Go to DONE with an error; no device access.
- REQ:
  - io_stall = 1; dev_* outputs held stable.
  - dev_ack[sel] = 1:
    - For a read, latch dev_rdata slice into io_rdata.
    - Deassert dev_sel on the next edge and go to DONE.
  - Acks from non-selected devices are ignored.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT, go to DONE with an error and io_rdata = 0.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as success; the ack wins.
- DONE (exactly one cycle):
  - io_stall = 0, so the CPU commits and advances.
  - io_rdata valid; io_err = 1 only for an errored access.
  - Strobes are ignored; unconditionally return to IDLE.
  - The next instruction's strobe is evaluated in IDLE on the following cycle.
- io_rdata holds its last value until the next latch or reset; writes leave it unchanged.
- Minimum latency:
  - Strobe cycle t, dev_sel from t+1.
  - Ack at t+1 gives DONE at t+2, so total stall = 2 cycles.

Optional Feature:
- Macro IO_BUS_SEQUENCER_STAT_EN.
- Defined:
  - Adds output io_count, 16 bits, reset 0.
  - Increments on each successful DONE and saturates at 0xFFFF.
  - Errored accesses are not counted.
- Undefined: port absent and counter logic removed; behaviour otherwise identical.

Test Plan:
- Reset release, no strobes, 10 cycles -> all outputs 0, state IDLE, io_stall = 0.
- Read, io_addr = 0x012, device 1 acks one cycle after sel with rdata 0xA5A5_0001:
  - dev_sel = 4'b0010, dev_addr = 2, dev_we = 0.
  - Stall for 2 cycles, then DONE with io_rdata = 0xA5A5_0001 and io_err = 0.
- Write, io_addr = 0x030, io_wdata = 0x55, device 3 acks after 5 cycles:
  - dev_sel = 4'b1000, dev_we = 1, dev_wdata = 0x55 held for all 5 cycles.
  - Stall for 6 cycles; io_rdata unchanged.
- Read of device 2 with no ack, TIMEOUT = 15:
  - dev_sel held for 15 REQ cycles.
  - Then DONE with io_err = 1 and io_rdata = 0.
  - Device 0 acking during this window has no effect.
- Back-to-back: read of device 0 immediately followed by a write to device 5 (NUM_DEV = 4):
  - First access completes normally.
  - Second gets no dev_sel and reaches DONE after 1 stall cycle with io_err = 1.
- Reset asserted in the 3rd REQ cycle:
  - dev_sel = 0 and io_stall = 0 immediately, state IDLE, no io_err pulse.
  - With STAT_EN defined, io_count is unchanged by the aborted access and then reset to 0.
